// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the registered N-input selector family.
// Mode encodings pick the channel-choice policy at elaboration time.
package mux_arb_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int MODE_SEL   = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Channel index width; never narrower than one bit even for a single channel.
    function automatic int idx_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mux_arb_reg_rr_arbiter.sv
// Round-robin grant search: starts one past the last-grant pointer and wraps
// over the NUM_IN valid indices only, so non-power-of-two sizes never alias.
module rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int  NUM_IN = 4,
    localparam int SEL_W  = idx_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic              en,
    output logic [NUM_IN-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx
);

    int   cand;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 1; i <= NUM_IN; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NUM_IN) begin
                cand = cand - NUM_IN;
            end
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = SEL_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mux_arb_reg.sv
// N-input registered selector with a one-entry output stage; channel choice
// is fixed priority, round-robin or external select depending on MODE.
module mux_arb_reg
    import mux_arb_pkg::*;
#(
    parameter int  WIDTH  = 32,
    parameter int  NUM_IN = 4,
    parameter int  MODE   = MODE_RR,
    localparam int SEL_W  = idx_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Handshake: a word moves on any port when valid && ready at a rising edge.
    // valid must not depend on ready; ready here is at most one-hot, only for a
    // channel whose valid is high, and only when the output stage can take data.
    logic                accept;
    logic [NUM_IN-1:0]   gnt;
    logic [SEL_W-1:0]    gnt_idx;
    logic                xfer;
    logic [WIDTH-1:0]    chan [NUM_IN];

    assign accept   = !out_valid || out_ready;
    assign in_ready = gnt;
    assign xfer     = |gnt;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_chan
        assign chan[i] = in_data[i*WIDTH +: WIDTH];
    end

    if (MODE == MODE_RR) begin : g_rr
        logic [SEL_W-1:0] rr_ptr;
        logic             unused_sel;

        assign unused_sel = ^sel;

        rr_arbiter #(.NUM_IN(NUM_IN)) u_rr (
            .req     (in_valid),
            .ptr     (rr_ptr),
            .en      (accept),
            .gnt     (gnt),
            .gnt_idx (gnt_idx)
        );

        // Pointer starts at the last channel so channel 0 wins first after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rr_ptr <= SEL_W'(NUM_IN - 1);
            end else if (xfer) begin
                rr_ptr <= gnt_idx;
            end
        end
    end else if (MODE == MODE_FIXED) begin : g_fixed
        logic found;
        logic unused_sel;

        assign unused_sel = ^sel;

        always_comb begin
            gnt     = '0;
            gnt_idx = '0;
            found   = 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (accept && !found && in_valid[i]) begin
                    found   = 1'b1;
                    gnt[i]  = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end
    end else begin : g_sel
        // Out-of-range select values match no channel and simply grant nothing.
        always_comb begin
            gnt     = '0;
            gnt_idx = '0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (accept && (int'(sel) == i) && in_valid[i]) begin
                    gnt[i]  = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end
    end

    // Data and index hold when the stage drains without a new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (accept) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= chan[gnt_idx];
                out_sel  <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Bench for mux_arb_reg: five instances (RR4, FIXED4, SEL4, SEL3, RR3) share a
// clock and reset; directed table vectors plus randomized traffic against a model.
module tb_mux_arb_reg;

    localparam int NI = 5;
    localparam int CFG_MODE [NI] = '{1, 0, 2, 2, 1};
    localparam int CFG_N    [NI] = '{4, 4, 4, 3, 3};

    logic clk;
    logic rst_n;

    logic [NI-1:0][127:0] in_data;
    logic [NI-1:0][3:0]   in_valid;
    logic [NI-1:0][1:0]   sel;
    logic [NI-1:0]        out_ready;

    logic [3:0]  rdy0, rdy1, rdy2;
    logic [2:0]  rdy3, rdy4;
    logic [31:0] od0, od1, od2, od3, od4;
    logic [1:0]  os0, os1, os2, os3, os4;
    logic        ov0, ov1, ov2, ov3, ov4;

    logic [NI-1:0][3:0]  in_ready;
    logic [NI-1:0][31:0] out_data;
    logic [NI-1:0][1:0]  out_sel;
    logic [NI-1:0]       out_valid;

    assign in_ready  = {{1'b0, rdy4}, {1'b0, rdy3}, rdy2, rdy1, rdy0};
    assign out_data  = {od4, od3, od2, od1, od0};
    assign out_sel   = {os4, os3, os2, os1, os0};
    assign out_valid = {ov4, ov3, ov2, ov1, ov0};

    mux_arb_reg #(.WIDTH(32), .NUM_IN(4), .MODE(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(rdy0), .sel(sel[0]), .out_data(od0), .out_sel(os0),
        .out_valid(ov0), .out_ready(out_ready[0]));

    mux_arb_reg #(.WIDTH(32), .NUM_IN(4), .MODE(0)) u_fx4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(rdy1), .sel(sel[1]), .out_data(od1), .out_sel(os1),
        .out_valid(ov1), .out_ready(out_ready[1]));

    mux_arb_reg #(.WIDTH(32), .NUM_IN(4), .MODE(2)) u_sl4 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(rdy2), .sel(sel[2]), .out_data(od2), .out_sel(os2),
        .out_valid(ov2), .out_ready(out_ready[2]));

    mux_arb_reg #(.WIDTH(32), .NUM_IN(3), .MODE(2)) u_sl3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[3][95:0]), .in_valid(in_valid[3][2:0]),
        .in_ready(rdy3), .sel(sel[3]), .out_data(od3), .out_sel(os3),
        .out_valid(ov3), .out_ready(out_ready[3]));

    mux_arb_reg #(.WIDTH(32), .NUM_IN(3), .MODE(1)) u_rr3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[4][95:0]), .in_valid(in_valid[4][2:0]),
        .in_ready(rdy4), .sel(sel[4]), .out_data(od4), .out_sel(os4),
        .out_valid(ov4), .out_ready(out_ready[4]));

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: output stage contents and round-robin pointer.
    logic        m_v   [NI];
    logic [31:0] m_d   [NI];
    int          m_s   [NI];
    int          m_p   [NI];
    int          m_g   [NI];
    logic        m_acc [NI];

    typedef struct {
        int         k;
        logic [3:0] valid;
        logic [1:0] s;
        logic       rdy;
        logic [3:0] exp_rdy;
        logic       exp_v;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%0h want=%0h", nm, k, act, exp);
        end
    endtask

    function automatic int pick(input int k, input logic [3:0] v, input int s, input int p);
        int n;
        int r;
        int c;
        n = CFG_N[k];
        r = -1;
        if (CFG_MODE[k] == 0) begin
            for (int i = 0; i < n; i++)
                if (r < 0 && v[i]) r = i;
        end else if (CFG_MODE[k] == 1) begin
            for (int j = 1; j <= n; j++) begin
                c = (p + j) % n;
                if (r < 0 && v[c]) r = c;
            end
        end else begin
            if (s < n && v[s]) r = s;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_v[k] = 1'b0;
            m_d[k] = '0;
            m_s[k] = 0;
            m_p[k] = CFG_N[k] - 1;
            m_g[k] = -1;
            m_acc[k] = 1'b1;
        end
    endtask

    task automatic model_check();
        logic [3:0] er;
        for (int k = 0; k < NI; k++) begin
            m_acc[k] = !m_v[k] || out_ready[k];
            m_g[k]   = m_acc[k] ? pick(k, in_valid[k], int'(sel[k]), m_p[k]) : -1;
            er       = (m_g[k] >= 0) ? 4'(1 << m_g[k]) : 4'b0000;
            chk("in_ready",  k, 32'(in_ready[k]),  32'(er));
            chk("out_valid", k, 32'(out_valid[k]), 32'(m_v[k]));
            chk("out_data",  k, out_data[k],       m_d[k]);
            chk("out_sel",   k, 32'(out_sel[k]),   32'(m_s[k]));
        end
    endtask

    task automatic model_advance();
        for (int k = 0; k < NI; k++) begin
            if (m_acc[k]) begin
                if (m_g[k] >= 0) begin
                    m_v[k] = 1'b1;
                    m_d[k] = in_data[k][m_g[k]*32 +: 32];
                    m_s[k] = m_g[k];
                    if (CFG_MODE[k] == 1) m_p[k] = m_g[k];
                end else begin
                    m_v[k] = 1'b0;
                end
            end
        end
    endtask

    // Driver tasks
    task automatic idle_all();
        for (int k = 0; k < NI; k++) begin
            in_valid[k]  = '0;
            out_ready[k] = 1'b1;
            sel[k]       = '0;
        end
    endtask

    task automatic step();
        model_check();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int k, input logic [3:0] v, input logic [1:0] s, input logic r,
                       input logic [3:0] er, input logic ev, input logic [1:0] es);
        vec_t e;
        e = '{k, v, s, r, er, ev, es};
        tbl.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        in_data[0] = {32'h12345678, 32'hDEADBEEF, 32'hB1B1B1B1, 32'hA0A0A0A0};
        for (int k = 1; k < NI; k++)
            for (int i = 0; i < 4; i++)
                in_data[k][i*32 +: 32] = 32'hC000_0000 | 32'(k << 8) | 32'(i);

        // RR4: first word, then fairness, back-pressure and drain.
        add(0, 4'b0100, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2);
        add(0, 4'b1000, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3);
        for (int i = 0; i < 8; i++)
            add(0, 4'b1111, 2'd0, 1'b1, 4'(1 << (i % 4)), 1'b1, 2'(i % 4));
        for (int i = 0; i < 3; i++)
            add(0, 4'b1111, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd3);
        add(0, 4'b1111, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0);
        add(0, 4'b0000, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd0);
        // FIXED4: channel 1 starves channel 3 until it drops.
        for (int i = 0; i < 3; i++)
            add(1, 4'b1010, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1);
        add(1, 4'b1000, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3);
        // SEL4 and SEL3, including out-of-range select.
        add(2, 4'b1001, 2'd3, 1'b1, 4'b1000, 1'b1, 2'd3);
        add(2, 4'b1001, 2'd2, 1'b1, 4'b0000, 1'b0, 2'd3);
        add(3, 4'b0010, 2'd1, 1'b1, 4'b0010, 1'b1, 2'd1);
        add(3, 4'b0111, 2'd3, 1'b1, 4'b0000, 1'b0, 2'd1);
        // RR3: wrap skips the missing index 3.
        for (int i = 0; i < 4; i++)
            add(4, 4'b0111, 2'd0, 1'b1, 4'(1 << (i % 3)), 1'b1, 2'(i % 3));

        // Reset state
        @(posedge clk);
        #1;
        model_reset();
        #2;
        model_check();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven vectors
        foreach (tbl[t]) begin
            idle_all();
            in_valid[tbl[t].k]  = tbl[t].valid;
            sel[tbl[t].k]       = tbl[t].s;
            out_ready[tbl[t].k] = tbl[t].rdy;
            #2;
            chk("tbl_rdy", tbl[t].k, 32'(in_ready[tbl[t].k]), 32'(tbl[t].exp_rdy));
            step();
            chk("tbl_valid", tbl[t].k, 32'(out_valid[tbl[t].k]), 32'(tbl[t].exp_v));
            chk("tbl_sel",   tbl[t].k, 32'(out_sel[tbl[t].k]),   32'(tbl[t].exp_sel));
            chk("tbl_data",  tbl[t].k, out_data[tbl[t].k],
                in_data[tbl[t].k][32'(tbl[t].exp_sel)*32 +: 32]);
        end

        // Asynchronous reset between edges while the stage holds a word.
        idle_all();
        in_valid[0] = 4'b0001;
        #2;
        step();
        chk("pre_rst_valid", 0, 32'(out_valid[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        idle_all();
        #1;
        chk("async_rst_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("async_rst_data",  0, out_data[0], 32'd0);
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 4'b1110;
        in_valid[4] = 4'b0110;
        #2;
        chk("post_rst_rdy_rr4", 0, 32'(in_ready[0]), 32'h2);
        chk("post_rst_rdy_rr3", 4, 32'(in_ready[4]), 32'h2);
        step();
        chk("post_rst_sel_rr4", 0, 32'(out_sel[0]), 32'd1);
        chk("post_rst_sel_rr3", 4, 32'(out_sel[4]), 32'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < NI; k++) begin
                in_valid[k]  = 4'($urandom_range(0, 15)) & ((CFG_N[k] == 4) ? 4'hF : 4'h7);
                out_ready[k] = ($urandom_range(0, 3) != 0);
                sel[k]       = 2'($urandom_range(0, 3));
                in_data[k]   = {$urandom, $urandom, $urandom, $urandom};
            end
            #2;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_arb_reg.md
Name: mux_arb_reg

Overview:
- Parametrised N-input, WIDTH-bit registered selector with valid/ready handshakes on every input and on the output.
- Successor to the datapath's plain 2:1 combinational 32-bit selector.
- Serves shared-resource paths in the CPU, e.g. writeback-port sharing and memory-request merging.
- Channel choice comes from fixed priority, round-robin arbitration, or an external select, chosen by parameter. The result is registered in a one-entry output stage.

Parameters:
- WIDTH, 32, data width of every channel
- NUM_IN, 4, number of input channels (2..16)
- MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin, 2 = external select via SEL
- SEL_W (localparam), max(1, clog2(NUM_IN)), width of channel index

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- IN_DATA  in  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- IN_VALID  in  NUM_IN  per-channel valid
- IN_READY  out  NUM_IN  per-channel ready, at most one bit high
- SEL  in  SEL_W  channel index, used only when MODE=2
- OUT_DATA  out  WIDTH  registered selected data
- OUT_SEL  out  SEL_W  index of the channel that supplied OUT_DATA
- OUT_VALID  out  1  output valid
- OUT_READY  in  1  downstream ready

Behaviour:
- Reset (RST_N low, asynchronous):
  - OUT_VALID=0, OUT_DATA=0, OUT_SEL=0.
  - Round-robin last-grant pointer = NUM_IN-1, so channel 0 has top priority first.
- Stage accept condition: accept = !OUT_VALID || OUT_READY. This is combinational, giving full throughput of one word per cycle.
- Grant is combinational from IN_VALID, SEL, the pointer and accept.
  - IN_READY[g]=1 only for the granted channel g, and only when accept=1 and IN_VALID[g]=1.
  - IN_READY is never high for a channel with IN_VALID low.
- Transfer on channel g: IN_VALID[g] && IN_READY[g] at the rising edge. Next cycle OUT_DATA = IN_DATA[g], OUT_SEL = g, OUT_VALID = 1. Latency is 1 cycle.
- Output stage update when accept=1 and no input transfers: OUT_VALID goes to 0. OUT_DATA and OUT_SEL hold their previous values.
- Stall (OUT_VALID && !OUT_READY): OUT_DATA, OUT_SEL and OUT_VALID hold stable, and all IN_READY = 0.
- MODE=0: g = lowest index with IN_VALID set.
- MODE=1:
  - Search starts at pointer+1 and wraps modulo NUM_IN. g = first channel found with IN_VALID set.
  - The pointer updates to g only on a transfer. It is unchanged on stall or idle.
- MODE=2:
  - g = SEL if SEL < NUM_IN and IN_VALID[SEL]; otherwise no grant.
  - SEL >= NUM_IN: no grant, no error, stage drains normally.
- Simultaneous output pop and input push in the same cycle: both occur; the new word replaces the old; OUT_VALID stays 1.
- Reset asserted mid-transfer: the word in the output stage is discarded. The upstream channel must not assume delivery of any word whose output handshake had not completed.
- Non-power-of-two NUM_IN: wrap-around skips indices >= NUM_IN.

Decomposition:
- Shared package mux_arb_pkg:
  - MODE constants MODE_FIXED=0, MODE_RR=1, MODE_SEL=2.
  - A clog2 helper function.
- One sub-module: rr_arbiter.
  - Parameter NUM_IN.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and grant index.
  - Covers the wrap-around search.
  - Instantiated only when MODE=1.
- Top level holds the data selection, output register, pointer register and the fixed/select paths.

Test Plan:
- Reset then idle, WIDTH=32, NUM_IN=4, MODE=1 -> OUT_VALID=0, OUT_DATA=0, all IN_READY=0. After RST_N rises, IN_VALID[2]=1 with IN_DATA[2]=32'hDEADBEEF -> next cycle OUT_DATA=32'hDEADBEEF, OUT_SEL=2, OUT_VALID=1.
- Round-robin fairness: all four IN_VALID held high and OUT_READY=1 for 8 cycles -> OUT_SEL sequence 0,1,2,3,0,1,2,3 with one word per cycle.
- Back-pressure: OUT_READY=0 for 3 cycles while OUT_VALID=1 with OUT_DATA=32'h12345678 -> OUT_DATA held stable, all IN_READY=0, pointer unchanged. OUT_READY=1 -> pending channel transfers the next cycle.
- MODE=0 priority: IN_VALID=4'b1010 -> channel 1 granted repeatedly and channel 3 starved while channel 1 stays valid. Drop IN_VALID[1] -> OUT_SEL=3.
- MODE=2 select: SEL=3 with IN_VALID=4'b1001 -> only IN_READY[3] asserted, OUT_SEL=3. With NUM_IN=3 and SEL=3 -> no IN_READY asserted, OUT_VALID falls to 0 after drain.
- Asynchronous reset mid-stream: assert RST_N low between clock edges while OUT_VALID=1 -> OUT_VALID=0 immediately, with no clock edge required. The first post-reset grant in MODE=1 goes to the lowest valid index.
